// File: rtl/dct_seq_pkg.sv
// Shared types for the DCT MAC sequencer: FSM state encoding and the
// control token that travels alongside each multiply through the macu.
package dct_seq_pkg;

  localparam int DCT_N_TAPS = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HOLD
  } seq_state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } ctl_tok_t;

  localparam int CTL_TOK_W = $bits(ctl_tok_t);

  function automatic ctl_tok_t make_tok(input logic valid, input logic first, input logic last);
    ctl_tok_t tok;
    tok.valid = valid;
    tok.first = valid & first;
    tok.last  = valid & last;
    return tok;
  endfunction

endpackage

// File: rtl/dct_ctl_delay.sv
// Delay line that keeps control tokens aligned with the multiplier result
// register; it advances only on the global clock enable.
module dct_ctl_delay
  import dct_seq_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ena,
  input  logic [CTL_TOK_W-1:0] i_tok_in,
  output logic [CTL_TOK_W-1:0] o_tok_out
);

  logic [CTL_TOK_W-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else if (i_ena) begin
      r_stage[0] <= i_tok_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tok_out = r_stage[DEPTH-1];

endmodule

// File: rtl/dct_mac_sequencer.sv
// Drives one dct_unit's multiplier/accumulator through N_TAPS steps per
// coefficient and hands the finished sum to the zigzag stage.
module dct_mac_sequencer
  import dct_seq_pkg::*;
#(
  parameter int N_TAPS   = DCT_N_TAPS,
  parameter int IDX_W    = 3,
  parameter int MULT_LAT = 1,
  parameter int RES_CNT  = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ena,
  input  logic             i_start,
  output logic             o_busy,
  input  logic             i_samp_valid,
  output logic             o_samp_ready,
  output logic [IDX_W-1:0] o_tap_idx,
  output logic             o_mult_en,
  output logic             o_acc_clr,
  output logic             o_acc_en,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [5:0]       o_res_idx
);

  seq_state_t       r_state;
  logic [IDX_W-1:0] r_tap;
  logic [5:0]       r_res_idx;
  logic             r_busy;
  logic             r_run;
  logic             r_res_valid;

  logic             w_issue;
  logic             w_tap_first;
  logic             w_tap_last;
  logic             w_drain_done;
  logic [5:0]       w_res_idx_next;
  ctl_tok_t         w_tok_in;
  ctl_tok_t         w_tok_out;

  assign w_issue      = r_run & i_samp_valid & i_ena;
  assign w_tap_first  = (r_tap == '0);
  assign w_tap_last   = (r_tap == IDX_W'(N_TAPS - 1));
  assign w_tok_in     = make_tok(w_issue, w_tap_first, w_tap_last);
  assign w_drain_done = w_tok_out.valid & w_tok_out.last & i_ena;

  assign w_res_idx_next = (r_res_idx == 6'(RES_CNT - 1)) ? 6'd0 : r_res_idx + 6'd1;

  // Tokens emerge exactly when the matching product sits in mult_res.
  dct_ctl_delay #(
    .DEPTH (MULT_LAT)
  ) u_ctl_delay (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_ena     (i_ena),
    .i_tok_in  (w_tok_in),
    .o_tok_out (w_tok_out)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_tap       <= '0;
      r_res_idx   <= '0;
      r_busy      <= 1'b0;
      r_run       <= 1'b0;
      r_res_valid <= 1'b0;
    end else if (i_ena) begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= RUN;
            r_tap   <= '0;
            r_busy  <= 1'b1;
            r_run   <= 1'b1;
          end
        end
        RUN: begin
          if (w_issue) begin
            if (w_tap_last) begin
              r_state <= DRAIN;
              r_tap   <= '0;
              r_run   <= 1'b0;
            end else begin
              r_tap <= r_tap + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (w_drain_done) begin
            r_state     <= HOLD;
            r_res_valid <= 1'b1;
          end
        end
        HOLD: begin
          // A start on the handshake cycle chains straight into the next result.
          if (i_res_ready) begin
            r_res_idx   <= w_res_idx_next;
            r_res_valid <= 1'b0;
            r_tap       <= '0;
            if (i_start) begin
              r_state <= RUN;
              r_run   <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_run       <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_samp_ready = r_run & i_ena;
  assign o_tap_idx    = r_tap;
  assign o_mult_en    = w_issue;
  assign o_acc_en     = w_tok_out.valid & i_ena;
  assign o_acc_clr    = w_tok_out.valid & w_tok_out.first & i_ena;
  assign o_res_valid  = r_res_valid;
  assign o_res_idx    = r_res_idx;

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Directed bench for dct_mac_sequencer with default parameters
// (8 taps, one-cycle multiplier, 64 results per block).
module tb_dct_mac_sequencer;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       start;
  logic       samp_valid;
  logic       res_ready;
  logic       busy;
  logic       samp_ready;
  logic [2:0] tap_idx;
  logic       mult_en;
  logic       acc_clr;
  logic       acc_en;
  logic       res_valid;
  logic [5:0] res_idx;

  int checks      = 0;
  int failures    = 0;
  int cycNum      = 0;
  int accEnCount  = 0;
  int accClrCount = 0;
  int tap2 [12]   = '{0, 1, 2, 3, 3, 3, 4, 5, 5, 5, 6, 7};

  dct_mac_sequencer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ena        (ena),
    .i_start      (start),
    .o_busy       (busy),
    .i_samp_valid (samp_valid),
    .o_samp_ready (samp_ready),
    .o_tap_idx    (tap_idx),
    .o_mult_en    (mult_en),
    .o_acc_clr    (acc_clr),
    .o_acc_en     (acc_en),
    .o_res_valid  (res_valid),
    .i_res_ready  (res_ready),
    .o_res_idx    (res_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One cycle: drive inputs at the falling edge, then sample 1 time unit later.
  task automatic applyStimulus(input logic st, input logic sv, input logic rr,
                               input logic en, input logic rs);
    @(negedge clk);
    start      = st;
    samp_valid = sv;
    res_ready  = rr;
    ena        = en;
    rst        = rs;
    #1;
    cycNum++;
    if (acc_en)  accEnCount++;
    if (acc_clr) accClrCount++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs with res_ready held high until the handshake cycle, bounded by budget.
  task automatic waitResValid(input int budget, input logic startNext,
                              input int expIdx, output int n);
    n = 0;
    do begin
      applyStimulus(startNext, 1'b1, 1'b1, 1'b1, 1'b0);
      n++;
    end while (!res_valid && n < budget);
    checkOutput("resValidSeen", res_valid, 1);
    checkOutput($sformatf("resIdxAtHandshake%0d", expIdx), res_idx, expIdx);
  endtask

  initial begin
    int n;
    int c0;
    int stray;
    logic sv;
    logic en;

    start = 0; samp_valid = 0; res_ready = 0; ena = 1; rst = 1;

    // Test 1: reset state and a clean accumulation.
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstSampReady", samp_ready, 0);
    checkOutput("rstTapIdx", tap_idx, 0);
    checkOutput("rstMultEn", mult_en, 0);
    checkOutput("rstAccClr", acc_clr, 0);
    checkOutput("rstAccEn", acc_en, 0);
    checkOutput("rstResValid", res_valid, 0);
    checkOutput("rstResIdx", res_idx, 0);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("idleNoIssue", mult_en, 0);
    accEnCount = 0; accClrCount = 0;
    applyStimulus(1, 1, 0, 1, 0);
    checkOutput("t1StartCycleIdle", busy, 0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(0, 1, 0, 1, 0);
      checkOutput($sformatf("t1Busy%0d", k), busy, 1);
      checkOutput($sformatf("t1MultEn%0d", k), mult_en, (k <= 8) ? 1 : 0);
      checkOutput($sformatf("t1SampReady%0d", k), samp_ready, (k <= 8) ? 1 : 0);
      checkOutput($sformatf("t1TapIdx%0d", k), tap_idx, (k <= 8) ? k - 1 : 0);
      checkOutput($sformatf("t1AccEn%0d", k), acc_en, (k >= 2 && k <= 9) ? 1 : 0);
      checkOutput($sformatf("t1AccClr%0d", k), acc_clr, (k == 2) ? 1 : 0);
      checkOutput($sformatf("t1ResValid%0d", k), res_valid, (k >= 10) ? 1 : 0);
    end
    checkOutput("t1ResIdx", res_idx, 0);
    checkOutput("t1AccEnTotal", accEnCount, 8);
    checkOutput("t1AccClrTotal", accClrCount, 1);
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t1BackIdle", busy, 0);
    checkOutput("t1ResValidDrop", res_valid, 0);
    checkOutput("t1ResIdxInc", res_idx, 1);

    // Test 2: sample bubbles on taps 3 and 5.
    accEnCount = 0; accClrCount = 0;
    applyStimulus(1, 1, 0, 1, 0);
    for (int k = 1; k <= 14; k++) begin
      sv = !(k == 4 || k == 5 || k == 8 || k == 9);
      applyStimulus(0, sv, 0, 1, 0);
      if (k <= 12) begin
        checkOutput($sformatf("t2TapIdx%0d", k), tap_idx, tap2[k-1]);
        checkOutput($sformatf("t2MultEn%0d", k), mult_en, sv ? 1 : 0);
      end
      checkOutput($sformatf("t2ResValid%0d", k), res_valid, (k == 14) ? 1 : 0);
    end
    checkOutput("t2AccEnTotal", accEnCount, 8);
    checkOutput("t2AccClrTotal", accClrCount, 1);
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t2ResIdx", res_idx, 2);

    // Test 3: res_ready withheld in HOLD, start pulsed in DRAIN.
    applyStimulus(1, 1, 0, 1, 0);
    for (int k = 1; k <= 8; k++) applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(1, 1, 0, 1, 0);
    checkOutput("t3DrainBusy", busy, 1);
    checkOutput("t3DrainSampReady", samp_ready, 0);
    for (int k = 10; k <= 14; k++) begin
      applyStimulus(0, 1, 0, 1, 0);
      checkOutput($sformatf("t3HoldResValid%0d", k), res_valid, 1);
      checkOutput($sformatf("t3HoldNoIssue%0d", k), mult_en, 0);
    end
    applyStimulus(0, 1, 1, 1, 0);
    checkOutput("t3HsResValid", res_valid, 1);
    checkOutput("t3HsResIdx", res_idx, 2);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("t3IdleAfterHs", busy, 0);
    checkOutput("t3ResIdx", res_idx, 3);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("t3StartIgnored", busy, 0);

    // Test 4: handshake and start in the same HOLD cycle.
    applyStimulus(1, 1, 0, 1, 0);
    for (int k = 1; k <= 9; k++) applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(1, 1, 1, 1, 0);
    checkOutput("t4HsResValid", res_valid, 1);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("t4ChainBusy", busy, 1);
    checkOutput("t4ChainSampReady", samp_ready, 1);
    checkOutput("t4ChainTapIdx", tap_idx, 0);
    checkOutput("t4ChainMultEn", mult_en, 1);
    checkOutput("t4ChainResValid", res_valid, 0);
    checkOutput("t4ChainResIdx", res_idx, 4);
    waitResValid(20, 0, 4, n);
    checkOutput("t4ChainLatency", n, 9);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t4ResIdx", res_idx, 5);

    // Test 5: clock enable low for three cycles at tap 4.
    accEnCount = 0; accClrCount = 0;
    applyStimulus(1, 1, 0, 1, 0);
    for (int k = 1; k <= 13; k++) begin
      en = !(k >= 5 && k <= 7);
      applyStimulus(0, 1, 0, en, 0);
      checkOutput($sformatf("t5MultEn%0d", k), mult_en, (en && k <= 11) ? 1 : 0);
      checkOutput($sformatf("t5AccEn%0d", k), acc_en,
                  ((k >= 2 && k <= 4) || (k >= 8 && k <= 12)) ? 1 : 0);
      checkOutput($sformatf("t5ResValid%0d", k), res_valid, (k == 13) ? 1 : 0);
      if (k >= 5 && k <= 8) begin
        checkOutput($sformatf("t5TapHold%0d", k), tap_idx, 4);
        checkOutput($sformatf("t5SampReady%0d", k), samp_ready, en ? 1 : 0);
      end
    end
    checkOutput("t5AccEnTotal", accEnCount, 8);
    checkOutput("t5AccClrTotal", accClrCount, 1);
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t5ResIdx", res_idx, 6);

    // Test 6: reset at tap 6, then 64 back-to-back results.
    applyStimulus(1, 1, 0, 1, 0);
    for (int k = 1; k <= 6; k++) applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 1);
    checkOutput("t6TapBeforeRst", tap_idx, 6);
    accEnCount = 0; accClrCount = 0;
    stray = 0;
    for (int k = 8; k <= 12; k++) begin
      applyStimulus(0, 1, 0, 1, 0);
      if (busy) stray++;
    end
    checkOutput("t6NoStrayAccEn", accEnCount, 0);
    checkOutput("t6NoStrayAccClr", accClrCount, 0);
    checkOutput("t6IdleAfterRst", stray, 0);
    checkOutput("t6ResIdxCleared", res_idx, 0);
    checkOutput("t6TapCleared", tap_idx, 0);

    applyStimulus(1, 1, 1, 1, 0);
    c0 = cycNum;
    for (int i = 0; i < 64; i++) begin
      waitResValid(20, (i < 63) ? 1'b1 : 1'b0, i, n);
      checkOutput($sformatf("t6Period%0d", i), n, 10);
    end
    checkOutput("t6TotalCycles", cycNum - c0, 640);
    checkOutput("t6AccEnTotal", accEnCount, 512);
    checkOutput("t6AccClrTotal", accClrCount, 64);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t6ResIdxWrap", res_idx, 0);
    checkOutput("t6FinalIdle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
